// File: rtl/fitness_pkg.sv
// Shared codes and thresholds for the fitness-tracker datapath.
// Holds the heart-rate classification, workout-intensity and comparator
// codes, the bpm thresholds, and a helper that classifies one heart rate.
package fitness_pkg;

    typedef enum logic [1:0] {
        SAFE      = 2'b00,
        WARNING   = 2'b01,
        EMERGENCY = 2'b10
    } hr_class_e;

    typedef enum logic [1:0] {
        WARMUP         = 2'b00,
        FAT_BURN       = 2'b01,
        INTENSE_CARDIO = 2'b10
    } intensity_e;

    typedef enum logic [1:0] {
        SAME   = 2'b00,
        HIGHER = 2'b01,
        LOWER  = 2'b10
    } hr_cmp_e;

    // Instantaneous heart-rate thresholds (bpm)
    localparam logic [7:0]  HR_WARN    = 8'd140;
    localparam logic [7:0]  HR_EMERG   = 8'd170;
    // Average heart-rate thresholds, sized to the averaged output
    localparam logic [31:0] INT_FAT    = 32'd130;
    localparam logic [31:0] INT_CARDIO = 32'd150;

    function automatic hr_class_e classify_hr(input logic [7:0] hr);
        if (hr >= HR_EMERG)     return EMERGENCY;
        else if (hr >= HR_WARN) return WARNING;
        else                    return SAFE;
    endfunction

endpackage

// File: rtl/heart_rate_step_comparator.sv
// Purely combinational comparison of the current sample against the
// previous one.
//   hr_input, previous_hr        : heart rates (bpm)
//   steps_input, previous_steps  : steps-per-second values
//   hr_comparison                : SAME / HIGHER / LOWER (11 never driven)
//   step_feedback                : 1 = keeping pace, 0 = go faster
module heart_rate_step_comparator
    import fitness_pkg::*;
(
    input  logic [7:0] hr_input,
    input  logic [7:0] previous_hr,
    input  logic [1:0] steps_input,
    input  logic [1:0] previous_steps,
    output logic [1:0] hr_comparison,
    output logic       step_feedback
);

    always_comb begin
        hr_comparison = SAME;
        if (hr_input > previous_hr)      hr_comparison = HIGHER;
        else if (hr_input < previous_hr) hr_comparison = LOWER;
    end

    assign step_feedback = (steps_input >= previous_steps);

endmodule

// File: rtl/step_calculator_dataflow.sv
// Fitness-tracker datapath: one sample per valid clock edge (one second).
// Accumulates steps, distance, elapsed time, calories and heart-rate sum,
// tracks peak heart rate and classifies the latest sample; the average
// heart rate and workout intensity are derived combinationally.
//   clk, rst (sync, active high)    : clock and reset
//   hr_input, steps_per_second,
//   stride_length, valid_input      : sensor sample and its strobe
//   previous_hr, previous_steps     : comparator reference values
//   total_steps/distance/calories,
//   time_elapsed, max_heart_rate,
//   heart_rate_classification       : registered statistics
//   average_heart_rate,
//   workout_intensity, hr_comparison,
//   step_feedback                   : combinational results
module step_calculator_dataflow
    import fitness_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  hr_input,
    input  logic [1:0]  steps_per_second,
    input  logic [7:0]  stride_length,
    input  logic        valid_input,
    input  logic [7:0]  previous_hr,
    input  logic [1:0]  previous_steps,
    output logic [15:0] total_steps,
    output logic [31:0] total_distance,
    output logic [7:0]  time_elapsed,
    output logic [1:0]  heart_rate_classification,
    output logic [7:0]  max_heart_rate,
    output logic [31:0] total_calories,
    output logic [31:0] average_heart_rate,
    output logic [1:0]  workout_intensity,
    output logic [1:0]  hr_comparison,
    output logic        step_feedback
);

    logic [31:0] hr_sum;
    logic [15:0] sample_count;
    logic [9:0]  dist_inc;

    // Max product 3 * 255 = 765 fits in 10 bits
    assign dist_inc = {8'd0, steps_per_second} * {2'd0, stride_length};

    always_ff @(posedge clk) begin
        if (rst) begin
            total_steps               <= '0;
            total_distance            <= '0;
            time_elapsed              <= '0;
            heart_rate_classification <= '0;
            max_heart_rate            <= '0;
            total_calories            <= '0;
            hr_sum                    <= '0;
            sample_count              <= '0;
        end else if (valid_input) begin
            total_steps    <= total_steps + {14'd0, steps_per_second};
            total_distance <= total_distance + {22'd0, dist_inc};
            // Elapsed time freezes at 255; every other accumulator wraps
            if (time_elapsed != 8'hFF)
                time_elapsed <= time_elapsed + 8'd1;
            sample_count   <= sample_count + 16'd1;
            hr_sum         <= hr_sum + {24'd0, hr_input};
            if (hr_input > max_heart_rate)
                max_heart_rate <= hr_input;
            total_calories <= total_calories + {28'd0, hr_input[7:4]}
                                             + {30'd0, steps_per_second};
            heart_rate_classification <= classify_hr(hr_input);
        end
    end

    // Guard the divide so an empty session reads as 0 rather than X
    always_comb begin
        average_heart_rate = '0;
        if (sample_count != 16'd0)
            average_heart_rate = hr_sum / {16'd0, sample_count};
    end

    always_comb begin
        workout_intensity = WARMUP;
        if (average_heart_rate >= INT_CARDIO)   workout_intensity = INTENSE_CARDIO;
        else if (average_heart_rate >= INT_FAT) workout_intensity = FAT_BURN;
    end

    heart_rate_step_comparator u_cmp (
        .hr_input       (hr_input),
        .previous_hr    (previous_hr),
        .steps_input    (steps_per_second),
        .previous_steps (previous_steps),
        .hr_comparison  (hr_comparison),
        .step_feedback  (step_feedback)
    );

endmodule

// File: tb/tb_step_calculator_dataflow.sv
module tb_step_calculator_dataflow;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  hr_input = '0;
    logic [1:0]  steps_per_second = '0;
    logic [7:0]  stride_length = '0;
    logic        valid_input = 1'b0;
    logic [7:0]  previous_hr = '0;
    logic [1:0]  previous_steps = '0;
    logic [15:0] total_steps;
    logic [31:0] total_distance;
    logic [7:0]  time_elapsed;
    logic [1:0]  heart_rate_classification;
    logic [7:0]  max_heart_rate;
    logic [31:0] total_calories;
    logic [31:0] average_heart_rate;
    logic [1:0]  workout_intensity;
    logic [1:0]  hr_comparison;
    logic        step_feedback;

    int checks = 0;
    int failures = 0;

    // Behavioural session model: plain integer arithmetic on whole samples
    longint m_steps, m_dist, m_time, m_cnt, m_sum, m_max, m_cal, m_class;

    always #5 clk = ~clk;

    step_calculator_dataflow dut (
        .clk                       (clk),
        .rst                       (rst),
        .hr_input                  (hr_input),
        .steps_per_second          (steps_per_second),
        .stride_length             (stride_length),
        .valid_input               (valid_input),
        .previous_hr               (previous_hr),
        .previous_steps            (previous_steps),
        .total_steps               (total_steps),
        .total_distance            (total_distance),
        .time_elapsed              (time_elapsed),
        .heart_rate_classification (heart_rate_classification),
        .max_heart_rate            (max_heart_rate),
        .total_calories            (total_calories),
        .average_heart_rate        (average_heart_rate),
        .workout_intensity         (workout_intensity),
        .hr_comparison             (hr_comparison),
        .step_feedback             (step_feedback)
    );

    function automatic longint exp_avg();
        return (m_cnt == 0) ? 0 : m_sum / m_cnt;
    endfunction

    function automatic longint exp_intensity();
        longint a = exp_avg();
        return (a >= 150) ? 2 : (a >= 130) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_steps = 0; m_dist = 0; m_time = 0; m_cnt = 0;
        m_sum = 0; m_max = 0; m_cal = 0; m_class = 0;
    endtask

    task automatic model_sample(input int hr, input int st, input int stride);
        m_steps = (m_steps + st) % 65536;
        m_dist  = (m_dist + st * stride) % 64'h1_0000_0000;
        m_time  = (m_time < 255) ? m_time + 1 : 255;
        m_cnt   = (m_cnt + 1) % 65536;
        m_sum   = (m_sum + hr) % 64'h1_0000_0000;
        m_max   = (hr > m_max) ? hr : m_max;
        m_cal   = (m_cal + hr / 16 + st) % 64'h1_0000_0000;
        m_class = (hr >= 170) ? 2 : (hr >= 140) ? 1 : 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid_input = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One single-edge valid sample, outputs sampled 1 time unit after the edge
    task automatic drive_sample(input int hr, input int st, input int stride);
        hr_input = 8'(hr);
        steps_per_second = 2'(st);
        stride_length = 8'(stride);
        valid_input = 1'b1;
        @(posedge clk); #1;
        valid_input = 1'b0;
        model_sample(hr, st, stride);
    endtask

    task automatic test_reset();
        hr_input = 8'd200; steps_per_second = 2'd3; stride_length = 8'd90;
        drive_sample(200, 3, 90);
        do_reset();
        checks++; if (total_steps !== 16'd0) begin failures++; $display("FAIL reset_steps got=%0d want=0", total_steps); end
        checks++; if (total_distance !== 32'd0) begin failures++; $display("FAIL reset_distance got=%0d want=0", total_distance); end
        checks++; if (time_elapsed !== 8'd0) begin failures++; $display("FAIL reset_time got=%0d want=0", time_elapsed); end
        checks++; if (max_heart_rate !== 8'd0) begin failures++; $display("FAIL reset_max got=%0d want=0", max_heart_rate); end
        checks++; if (total_calories !== 32'd0) begin failures++; $display("FAIL reset_cal got=%0d want=0", total_calories); end
        checks++; if (heart_rate_classification !== 2'd0) begin failures++; $display("FAIL reset_class got=%0d want=0", heart_rate_classification); end
        checks++; if (average_heart_rate !== 32'd0) begin failures++; $display("FAIL reset_avg got=%0d want=0", average_heart_rate); end
        checks++; if (workout_intensity !== 2'd0) begin failures++; $display("FAIL reset_intensity got=%0d want=0", workout_intensity); end
    endtask

    task automatic test_reference_session();
        int hrs[10] = '{130, 140, 150, 160, 170, 160, 150, 140, 130, 120};
        int sts[5]  = '{2, 3, 0, 3, 2};
        do_reset();
        for (int i = 0; i < 20; i++) drive_sample(hrs[i % 10], sts[i % 5], 75);
        checks++; if (total_steps !== 16'd40) begin failures++; $display("FAIL ref_steps got=%0d want=40", total_steps); end
        checks++; if (total_distance !== 32'd3000) begin failures++; $display("FAIL ref_distance got=%0d want=3000", total_distance); end
        checks++; if (time_elapsed !== 8'd20) begin failures++; $display("FAIL ref_time got=%0d want=20", time_elapsed); end
        checks++; if (max_heart_rate !== 8'd170) begin failures++; $display("FAIL ref_max got=%0d want=170", max_heart_rate); end
        checks++; if (total_calories !== 32'd214) begin failures++; $display("FAIL ref_cal got=%0d want=214", total_calories); end
        checks++; if (average_heart_rate !== 32'd145) begin failures++; $display("FAIL ref_avg got=%0d want=145", average_heart_rate); end
        checks++; if (workout_intensity !== 2'b01) begin failures++; $display("FAIL ref_intensity got=%0d want=1", workout_intensity); end
        checks++; if (heart_rate_classification !== 2'b00) begin failures++; $display("FAIL ref_class got=%0d want=0", heart_rate_classification); end
    endtask

    task automatic test_classification();
        int hrs[4] = '{139, 140, 169, 170};
        logic [1:0] want[4] = '{2'b00, 2'b01, 2'b01, 2'b10};
        for (int i = 0; i < 4; i++) begin
            drive_sample(hrs[i], 1, 50);
            checks++;
            if (heart_rate_classification !== want[i]) begin
                failures++;
                $display("FAIL class_hr%0d got=%0d want=%0d", hrs[i], heart_rate_classification, want[i]);
            end
        end
    endtask

    task automatic test_comparator();
        int h[3] = '{130, 120, 150};
        int p[3] = '{120, 130, 150};
        logic [1:0] hw[3] = '{2'b01, 2'b10, 2'b00};
        int s[3] = '{3, 2, 0};
        int ps[3] = '{2, 2, 3};
        logic sw[3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            hr_input = 8'(h[i]); previous_hr = 8'(p[i]);
            steps_per_second = 2'(s[i]); previous_steps = 2'(ps[i]);
            #1;
            checks++; if (hr_comparison !== hw[i]) begin failures++; $display("FAIL cmp_hr%0d got=%0d want=%0d", i, hr_comparison, hw[i]); end
            checks++; if (step_feedback !== sw[i]) begin failures++; $display("FAIL cmp_steps%0d got=%0d want=%0d", i, step_feedback, sw[i]); end
        end
    endtask

    task automatic test_hold();
        do_reset();
        drive_sample(150, 2, 80);
        drive_sample(100, 1, 80);
        for (int i = 0; i < 10; i++) begin
            hr_input = 8'($urandom_range(0, 255));
            steps_per_second = 2'($urandom_range(0, 3));
            stride_length = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
        end
        checks++; if (total_steps !== 16'(m_steps)) begin failures++; $display("FAIL hold_steps got=%0d want=%0d", total_steps, m_steps); end
        checks++; if (total_distance !== 32'(m_dist)) begin failures++; $display("FAIL hold_distance got=%0d want=%0d", total_distance, m_dist); end
        checks++; if (time_elapsed !== 8'(m_time)) begin failures++; $display("FAIL hold_time got=%0d want=%0d", time_elapsed, m_time); end
        checks++; if (total_calories !== 32'(m_cal)) begin failures++; $display("FAIL hold_cal got=%0d want=%0d", total_calories, m_cal); end
        checks++; if (max_heart_rate !== 8'(m_max)) begin failures++; $display("FAIL hold_max got=%0d want=%0d", max_heart_rate, m_max); end
        checks++; if (average_heart_rate !== 32'(exp_avg())) begin failures++; $display("FAIL hold_avg got=%0d want=%0d", average_heart_rate, exp_avg()); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 255; i++) drive_sample(100, 3, 10);
        checks++; if (time_elapsed !== 8'd255) begin failures++; $display("FAIL sat_time255 got=%0d want=255", time_elapsed); end
        for (int i = 0; i < 5; i++) drive_sample(100, 3, 10);
        checks++; if (time_elapsed !== 8'd255) begin failures++; $display("FAIL sat_time_hold got=%0d want=255", time_elapsed); end
        checks++; if (total_steps !== 16'd780) begin failures++; $display("FAIL sat_steps got=%0d want=780", total_steps); end
        checks++; if (total_distance !== 32'd7800) begin failures++; $display("FAIL sat_distance got=%0d want=7800", total_distance); end
        checks++; if (average_heart_rate !== 32'd100) begin failures++; $display("FAIL sat_avg got=%0d want=100", average_heart_rate); end
    endtask

    task automatic test_priority();
        drive_sample(180, 3, 100);
        hr_input = 8'd200; steps_per_second = 2'd3; stride_length = 8'd100;
        rst = 1'b1; valid_input = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; valid_input = 1'b0;
        model_reset();
        checks++; if (total_steps !== 16'd0) begin failures++; $display("FAIL prio_steps got=%0d want=0", total_steps); end
        checks++; if (time_elapsed !== 8'd0) begin failures++; $display("FAIL prio_time got=%0d want=0", time_elapsed); end
        checks++; if (max_heart_rate !== 8'd0) begin failures++; $display("FAIL prio_max got=%0d want=0", max_heart_rate); end
        checks++; if (total_calories !== 32'd0) begin failures++; $display("FAIL prio_cal got=%0d want=0", total_calories); end
        checks++; if (heart_rate_classification !== 2'd0) begin failures++; $display("FAIL prio_class got=%0d want=0", heart_rate_classification); end
        checks++; if (average_heart_rate !== 32'd0) begin failures++; $display("FAIL prio_avg got=%0d want=0", average_heart_rate); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 80; i++) begin
            int hr = $urandom_range(60, 255);
            int st = $urandom_range(0, 3);
            int sd = $urandom_range(0, 255);
            int ph = $urandom_range(60, 255);
            int ps = $urandom_range(0, 3);
            logic v = 1'($urandom_range(0, 1));
            hr_input = 8'(hr); steps_per_second = 2'(st); stride_length = 8'(sd);
            previous_hr = 8'(ph); previous_steps = 2'(ps); valid_input = v;
            @(posedge clk); #1;
            if (v) model_sample(hr, st, sd);
            checks++;
            if (total_steps !== 16'(m_steps) || total_distance !== 32'(m_dist) ||
                time_elapsed !== 8'(m_time) || total_calories !== 32'(m_cal) ||
                max_heart_rate !== 8'(m_max) || heart_rate_classification !== 2'(m_class)) begin
                failures++;
                $display("FAIL rand_acc%0d got st=%0d d=%0d t=%0d c=%0d m=%0d cl=%0d want st=%0d d=%0d t=%0d c=%0d m=%0d cl=%0d",
                         i, total_steps, total_distance, time_elapsed, total_calories, max_heart_rate,
                         heart_rate_classification, m_steps, m_dist, m_time, m_cal, m_max, m_class);
            end
            checks++;
            if (average_heart_rate !== 32'(exp_avg()) || workout_intensity !== 2'(exp_intensity())) begin
                failures++;
                $display("FAIL rand_avg%0d got avg=%0d int=%0d want avg=%0d int=%0d",
                         i, average_heart_rate, workout_intensity, exp_avg(), exp_intensity());
            end
            checks++;
            if (hr_comparison !== ((hr > ph) ? 2'b01 : (hr < ph) ? 2'b10 : 2'b00) ||
                step_feedback !== (st >= ps)) begin
                failures++;
                $display("FAIL rand_cmp%0d got hc=%0d sf=%0d hr=%0d ph=%0d st=%0d ps=%0d",
                         i, hr_comparison, step_feedback, hr, ph, st, ps);
            end
        end
        valid_input = 1'b0;
    endtask

    initial begin
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_reference_session();
        test_classification();
        test_comparator();
        test_hold();
        test_saturation();
        test_priority();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
